// File: rtl/cpu_datapath.sv
// 16-bit datapath: IR, PC, SP, MAR and ALU accumulator around one internal bus.
// The control unit supplies all strobes; IR fields and MAR go back out as registered outputs.
module cpu_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_bus,
    input  logic [15:0] out,
    input  logic        ldIR,
    input  logic        ldMAR,
    input  logic        ldPC,
    input  logic        ldSP,
    input  logic        ldALUreg,
    input  logic        Tpc,
    input  logic        Tsp,
    input  logic        Tlabel,
    input  logic        ALUon,
    input  logic        mm,
    input  logic [2:0]  fnSelect,
    output logic [3:0]  ir_1,
    output logic [1:0]  ir_2,
    output logic [2:0]  funct,
    output logic [15:0] addr_bus
);
    logic [15:0] ir_q, pc_q, sp_q, mar_q, alu_q;
    logic [15:0] label, bus_d, opb, alu_d;

    assign label = {{6{ir_q[9]}}, ir_q[9:0]};

    // Fixed-priority mux stands in for a shared tri-state bus
    always_comb begin
        bus_d = data_bus;
        if (Tpc)         bus_d = pc_q;
        else if (Tsp)    bus_d = sp_q;
        else if (Tlabel) bus_d = label;
        else if (ALUon)  bus_d = alu_q;
    end

    assign opb = mm ? out : data_bus;

    always_comb begin
        alu_d = '0;
        unique case (fnSelect)
            3'b000: alu_d = alu_q + opb;
            3'b001: alu_d = alu_q - opb;
            3'b010: alu_d = alu_q & opb;
            3'b011: alu_d = alu_q | opb;
            3'b100: alu_d = alu_q ^ opb;
            3'b101: alu_d = ~alu_q;
            3'b110: alu_d = opb;
            3'b111: alu_d = {opb[14:0], 1'b0};
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q  <= '0;
            pc_q  <= '0;
            sp_q  <= '0;
            mar_q <= '0;
            alu_q <= '0;
        end else begin
            if (ldIR)     ir_q  <= data_bus;
            if (ldPC)     pc_q  <= bus_d;
            if (ldSP)     sp_q  <= bus_d;
            if (ldMAR)    mar_q <= bus_d;
            if (ldALUreg) alu_q <= alu_d;
        end
    end

    assign ir_1     = ir_q[15:12];
    assign ir_2     = ir_q[11:10];
    assign funct    = ir_q[2:0];
    assign addr_bus = mar_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: table of one-edge vectors plus reset sequences.
module tb_cpu_datapath;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_bus, out;
    logic        ldIR, ldMAR, ldPC, ldSP, ldALUreg, Tpc, Tsp, Tlabel, ALUon, mm;
    logic [2:0]  fnSelect;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2;
    logic [2:0]  funct;
    logic [15:0] addr_bus;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .rst_n(rst_n), .data_bus(data_bus), .out(out),
        .ldIR(ldIR), .ldMAR(ldMAR), .ldPC(ldPC), .ldSP(ldSP), .ldALUreg(ldALUreg),
        .Tpc(Tpc), .Tsp(Tsp), .Tlabel(Tlabel), .ALUon(ALUon), .mm(mm),
        .fnSelect(fnSelect), .ir_1(ir_1), .ir_2(ir_2), .funct(funct), .addr_bus(addr_bus)
    );

    localparam logic [9:0] LIR = 10'h200, LMAR = 10'h100, LPC = 10'h080, LSP = 10'h040,
                           LALU = 10'h020, TPC = 10'h010, TSP = 10'h008, TLB = 10'h004,
                           AON = 10'h002, MM = 10'h001;

    typedef struct {
        logic [9:0]  ctl;
        logic [2:0]  fn;
        logic [15:0] db;
        logic [15:0] op;
        logic [15:0] e_ir;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] e_ir, input logic [15:0] e_addr);
        chk({nm, ".ir_1"},  {12'h0, ir_1},  {12'h0, e_ir[15:12]});
        chk({nm, ".ir_2"},  {14'h0, ir_2},  {14'h0, e_ir[11:10]});
        chk({nm, ".funct"}, {13'h0, funct}, {13'h0, e_ir[2:0]});
        chk({nm, ".addr"},  addr_bus,       e_addr);
    endtask

    task automatic drive(input logic [9:0] ctl, input logic [2:0] fn,
                         input logic [15:0] db, input logic [15:0] op);
        {ldIR, ldMAR, ldPC, ldSP, ldALUreg, Tpc, Tsp, Tlabel, ALUon, mm} = ctl;
        fnSelect = fn;
        data_bus = db;
        out      = op;
    endtask

    task automatic add(input logic [9:0] ctl, input logic [2:0] fn, input logic [15:0] db,
                       input logic [15:0] op, input logic [15:0] e_ir, input logic [15:0] e_addr);
        vec_t v;
        v.ctl = ctl; v.fn = fn; v.db = db; v.op = op; v.e_ir = e_ir; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    initial begin
        // ctl, fn, data_bus, out, expected IR, expected addr_bus
        add(LIR,                   3'd0, 16'hF755, 16'h0000, 16'hF755, 16'h0000);
        add(TLB|LMAR,              3'd0, 16'h0000, 16'h0000, 16'hF755, 16'hFF55);
        add(TLB|LSP,               3'd0, 16'h0000, 16'h0000, 16'hF755, 16'hFF55);
        add(TPC|TSP|TLB|AON|LMAR,  3'd0, 16'h1111, 16'h0000, 16'hF755, 16'h0000);
        add(TSP|TLB|LMAR,          3'd0, 16'h1111, 16'h0000, 16'hF755, 16'hFF55);
        add(MM|LALU,               3'd0, 16'h0000, 16'h0005, 16'hF755, 16'hFF55);
        add(MM|LALU,               3'd1, 16'h0000, 16'h0007, 16'hF755, 16'hFF55);
        add(AON|LMAR,              3'd0, 16'h1111, 16'h0000, 16'hF755, 16'hFFFE);
        add(TSP|LPC|LMAR,          3'd0, 16'h1111, 16'h0000, 16'hF755, 16'hFF55);
        add(LMAR,                  3'd0, 16'h1234, 16'h0000, 16'hF755, 16'h1234);
        add(TPC|LMAR,              3'd0, 16'h1234, 16'h0000, 16'hF755, 16'hFF55);
        add(10'h000,               3'd0, 16'hBEEF, 16'hBEEF, 16'hF755, 16'hFF55);
        add(LIR|TLB|LMAR,          3'd0, 16'h0155, 16'h0000, 16'h0155, 16'hFF55);
        add(TLB|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'h0155);
        add(LALU,                  3'd2, 16'h0F0F, 16'h0000, 16'h0155, 16'h0155);
        add(AON|LALU|LMAR,         3'd3, 16'hF000, 16'h0000, 16'h0155, 16'h0F0E);
        add(AON|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'hFF0E);
        add(MM|LALU,               3'd4, 16'h0000, 16'h00FF, 16'h0155, 16'hFF0E);
        add(LALU,                  3'd5, 16'h0000, 16'h0000, 16'h0155, 16'hFF0E);
        add(AON|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'h000E);
        add(LALU,                  3'd7, 16'h8003, 16'h0000, 16'h0155, 16'h000E);
        add(AON|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'h0006);
        add(MM|LALU|LMAR,          3'd6, 16'h1357, 16'hABCD, 16'h0155, 16'h1357);
        add(AON|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'hABCD);
        add(MM|LALU,               3'd0, 16'h0000, 16'h5433, 16'h0155, 16'hABCD);
        add(AON|LMAR,              3'd0, 16'h0000, 16'h0000, 16'h0155, 16'h0000);
        add(LMAR,                  3'd0, 16'h2468, 16'h0000, 16'h0155, 16'h2468);

        rst_n = 1'b0;
        drive(10'h000, 3'd0, 16'h0000, 16'h0000);
        #3;
        chk_all("reset", 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].fn, vecs[i].db, vecs[i].op);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_addr);
        end

        // Mid-cycle reset while strobes are active clears everything at once
        @(negedge clk);
        drive(LIR|TLB|LMAR|LALU|MM, 3'd6, 16'hAAAA, 16'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_held", 16'h0000, 16'h0000);

        // Release mid-cycle: first rising edge must load; label comes from cleared IR
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 16'hAAAA, 16'h0000);
        @(negedge clk);
        drive(AON|LMAR, 3'd0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        chk_all("post_rst_alu", 16'hAAAA, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
